// File: rtl/vend_controller.sv
// Vending transaction controller: takes key events, builds coin credit, checks
// selections against fixed prices, times the dispense strobe and returns change.
module vend_controller #(
  parameter int PRICE_A     = 25,
  parameter int PRICE_B     = 50,
  parameter int PRICE_C     = 75,
  parameter int PRICE_D     = 100,
  parameter int MAX_CREDIT  = 250,
  parameter int DISP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] credit,
  output logic       dispense,
  output logic [1:0] item,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       deny,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CREDIT   = 3'd1;
  localparam logic [2:0] S_DISPENSE = 3'd2;
  localparam logic [2:0] S_CHANGE   = 3'd3;
  localparam logic [2:0] S_REFUND   = 3'd4;

  localparam int CW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  logic [2:0]    r_state;
  logic [7:0]    r_credit;
  logic [7:0]    r_pending;
  logic [CW-1:0] r_count;
  logic          r_dispense;
  logic [1:0]    r_item;
  logic [7:0]    r_change;
  logic          r_changeValid;
  logic          r_coinReject;
  logic          r_deny;
  logic          r_busy;

  logic          w_isCoin;
  logic          w_isSelect;
  logic          w_isCancel;
  logic [7:0]    w_coinValue;
  logic [1:0]    w_selIdx;
  logic [7:0]    w_price;
  logic [8:0]    w_sum;
  logic          w_coinFits;
  logic          w_canBuy;

  always_comb begin
    w_isCoin    = 1'b0;
    w_isSelect  = 1'b0;
    w_isCancel  = 1'b0;
    w_coinValue = 8'd0;
    w_selIdx    = key_code[1:0];
    case (key_code)
      4'd1:    begin w_isCoin = 1'b1; w_coinValue = 8'd5;  end
      4'd2:    begin w_isCoin = 1'b1; w_coinValue = 8'd10; end
      4'd3:    begin w_isCoin = 1'b1; w_coinValue = 8'd25; end
      4'd4, 4'd5, 4'd6, 4'd7: w_isSelect = 1'b1;
      4'hF:    w_isCancel = 1'b1;
      default: ;
    endcase
    case (w_selIdx)
      2'd0:    w_price = 8'(PRICE_A);
      2'd1:    w_price = 8'(PRICE_B);
      2'd2:    w_price = 8'(PRICE_C);
      default: w_price = 8'(PRICE_D);
    endcase
    // Nine-bit sum so a coin that would push past the ceiling is caught, not wrapped.
    w_sum      = {1'b0, r_credit} + {1'b0, w_coinValue};
    w_coinFits = (w_sum <= 9'(MAX_CREDIT));
    w_canBuy   = (r_credit >= w_price);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= 8'd0;
      r_pending     <= 8'd0;
      r_count       <= '0;
      r_dispense    <= 1'b0;
      r_item        <= 2'd0;
      r_change      <= 8'd0;
      r_changeValid <= 1'b0;
      r_coinReject  <= 1'b0;
      r_deny        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_changeValid <= 1'b0;
      r_coinReject  <= 1'b0;
      r_deny        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_valid && w_isCoin) begin
            r_credit <= w_coinValue;
            r_state  <= S_CREDIT;
          end else if (key_valid && w_isSelect) begin
            r_deny <= 1'b1;
          end
        end
        S_CREDIT: begin
          if (key_valid && w_isCoin) begin
            if (w_coinFits) r_credit <= w_sum[7:0];
            else            r_coinReject <= 1'b1;
          end else if (key_valid && w_isSelect) begin
            if (w_canBuy) begin
              r_item     <= w_selIdx;
              r_pending  <= r_credit - w_price;
              r_credit   <= 8'd0;
              r_dispense <= 1'b1;
              r_busy     <= 1'b1;
              r_count    <= CW'(DISP_CYCLES - 1);
              r_state    <= S_DISPENSE;
            end else begin
              r_deny <= 1'b1;
            end
          end else if (key_valid && w_isCancel) begin
            r_change      <= r_credit;
            r_changeValid <= 1'b1;
            r_credit      <= 8'd0;
            r_busy        <= 1'b1;
            r_state       <= S_REFUND;
          end
        end
        S_DISPENSE: begin
          // The strobe was raised on the accepting edge, so the counter starts one short.
          if (r_count == '0) begin
            r_dispense <= 1'b0;
            if (r_pending != 8'd0) begin
              r_change      <= r_pending;
              r_changeValid <= 1'b1;
              r_state       <= S_CHANGE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_CHANGE, S_REFUND: begin
          r_pending <= 8'd0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign credit       = r_credit;
  assign dispense     = r_dispense;
  assign item         = r_item;
  assign change       = r_change;
  assign change_valid = r_changeValid;
  assign coin_reject  = r_coinReject;
  assign deny         = r_deny;
  assign busy         = r_busy;

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller for the vending machine, directly downstream of the debounced keypad path. Consumes one-cycle key events, accumulates coin credit, validates product selections against fixed prices, times the dispense strobe and reports change or refund. Its `credit` output replaces the raw counter value as the source for the binary-to-BCD / seven-segment display chain.

## Interface
- `PRICE_A`, 25, price of product A (key 4)
- `PRICE_B`, 50, price of product B (key 5)
- `PRICE_C`, 75, price of product C (key 6)
- `PRICE_D`, 100, price of product D (key 7)
- `MAX_CREDIT`, 250, credit ceiling (must be ≤255)
- `DISP_CYCLES`, 8, dispense strobe length in clocks (≥1)

- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `key_valid`  in  1  one-cycle pulse, `key_code` valid
- `key_code`  in  4  decoded key value
- `credit`  out  8  current credit, binary, feeds display
- `dispense`  out  1  high for DISP_CYCLES while vending
- `item`  out  2  selected product (0=A..3=D), held from accept until next accept
- `change`  out  8  change/refund amount, held until next change_valid
- `change_valid`  out  1  one-cycle pulse, `change` valid
- `coin_reject`  out  1  one-cycle pulse, coin refused (would exceed MAX_CREDIT)
- `deny`  out  1  one-cycle pulse, selection refused (insufficient credit)
- `busy`  out  1  high in DISPENSE, CHANGE, REFUND

## Operation
- Key decode: 1→coin 5, 2→coin 10, 3→coin 25; 4..7→select A..D; 4'hF→cancel; all other codes ignored (no state change, no pulse).
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE, REFUND.
- IDLE: coin → credit=value, go CREDIT. Select → `deny` pulse, stay. Cancel → no-op.
- CREDIT: coin → if credit+value ≤ MAX_CREDIT, add; else `coin_reject`, credit unchanged. Select i → if credit ≥ price_i: latch `item`=i, latch pending change = credit−price_i, credit=0, go DISPENSE; else `deny`, credit unchanged. Cancel → pending change = credit, credit=0, go REFUND.
- DISPENSE: `dispense`=1 for exactly DISP_CYCLES cycles (internal down-counter); then CHANGE if pending change ≠0, else IDLE.
- CHANGE / REFUND: one cycle; `change`=pending, `change_valid`=1; go IDLE.
- `key_valid` while `busy` is ignored entirely: no pulses, no credit change.
- Add arithmetic done at 9 bits to detect overflow; credit never exceeds MAX_CREDIT.
- Exact-price purchase: no `change_valid` pulse; `change` keeps previous value.

## Timing
- All outputs registered. Reset values: credit 0, dispense 0, item 0, change 0, change_valid 0, coin_reject 0, deny 0, busy 0, state IDLE, counters 0.
- Key sampled at rising edge with key_valid=1; `credit`, `coin_reject`, `deny` update at that edge (visible next cycle).
- Accepted selection at edge E: `dispense` and `busy` high from E through E+DISP_CYCLES−1 edges (DISP_CYCLES cycles), `credit`=0 from E.
- `change_valid` high in the cycle immediately after `dispense` falls; `busy` stays high that cycle, low the next.
- Cancel at edge E: REFUND cycle follows E; `change_valid` high exactly one cycle; `busy` high that one cycle.
- Back-to-back key pulses in consecutive cycles each processed (when not busy).
- Reset asserted mid-DISPENSE/CHANGE: all outputs clear immediately (asynchronous), credit and pending change lost, no change pulse afterwards.

## Test plan
- Keys 3,3,3 → credit 25,50,75; key 5 → dispense high 8 cycles, item=1, credit 0, then change_valid with change=25, busy low next cycle.
- Ten key 3 → credit 250; key 3 again → coin_reject one cycle, credit stays 250; key 1 → coin_reject, credit 250.
- Key 2 (credit 10), key 7 → deny one cycle, credit 10, dispense stays 0; key 4 in IDLE after reset → deny.
- Keys 3,2 (credit 35), key F → REFUND: change_valid one cycle, change=35, credit 0, state IDLE; key F again → nothing.
- Key 3, key 4 → dispense 8 cycles, no change_valid; keys 3 and 4 pulsed during dispense → ignored, credit remains 0 after.
- Credit 100, key 7, reset at dispense cycle 3 → all outputs 0 same cycle, no change_valid after reset release.
